instr_align: RTL



---
 rtl/instr_align.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/instr_align.sv
// Instruction-align stage: splits fetch words into halfwords and
// emits one registered 16- or 32-bit instruction per cycle.
module instr_align #(
    parameter int XLEN     = 32,
    parameter int HQ_DEPTH = 4,
    parameter int EXC_W    = 5
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_flush,
    input  logic             i_stall,
    input  logic             i_fetch_valid,
    output logic             o_fetch_ready,
    input  logic [XLEN-1:0]  i_fetch_pc,
    input  logic [31:0]      i_fetch_data,
    input  logic             i_fetch_except_valid,
    input  logic [EXC_W-1:0] i_fetch_except_code,
    output logic             o_valid,
    output logic [XLEN-1:0]  o_pc,
    output logic [31:0]      o_instr,
    output logic             o_half,
    output logic             o_except_valid,
    output logic [EXC_W-1:0] o_except_code
);

    localparam int PW = $clog2(HQ_DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [15:0]      data;
        logic [XLEN-1:0]  pc;
        logic             exc_v;
        logic [EXC_W-1:0] code;
    } hq_ent_t;

    hq_ent_t         q [HQ_DEPTH];
    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;
    logic [PW-1:0]   head_nx;
    logic [PW-1:0]   tail_nx;
    logic [CW-1:0]   count;
    logic            halted;

    logic            fire;
    logic [1:0]      push_n;
    hq_ent_t         e0;
    hq_ent_t         e1;

    hq_ent_t         h0;
    logic [1:0]      pop_n;
    logic            set_halt;
    logic            nxt_valid;
    logic [XLEN-1:0] nxt_pc;
    logic [31:0]     nxt_instr;
    logic            nxt_half;
    logic            nxt_exv;
    logic [EXC_W-1:0] nxt_exc;

    assign head_nx = head + PW'(1);
    assign tail_nx = tail + PW'(1);
    assign h0      = q[head];

    // Ready depends on registered state only, so a push of two always fits.
    assign o_fetch_ready = ~halted & (count <= CW'(HQ_DEPTH - 2));
    assign fire          = i_fetch_valid & o_fetch_ready;

    // Build the entries a fetch word contributes to the queue.
    always_comb begin
        push_n   = 2'd0;
        e0       = '0;
        e1       = '0;
        e0.pc    = i_fetch_pc;
        e1.pc    = i_fetch_pc + XLEN'(2);
        e1.data  = i_fetch_data[31:16];
        if (fire) begin
            if (i_fetch_except_valid) begin
                push_n   = 2'd1;
                e0.exc_v = 1'b1;
                e0.code  = i_fetch_except_code;
            end else if (!i_fetch_pc[1]) begin
                push_n  = 2'd2;
                e0.data = i_fetch_data[15:0];
            end else begin
                push_n  = 2'd1;
                e0.data = i_fetch_data[31:16];
            end
        end
    end

    // Pick the next aligned instruction from the queue head.
    always_comb begin
        pop_n     = 2'd0;
        set_halt  = 1'b0;
        nxt_valid = 1'b0;
        nxt_pc    = '0;
        nxt_instr = '0;
        nxt_half  = 1'b0;
        nxt_exv   = 1'b0;
        nxt_exc   = '0;
        if (halted || count == '0) begin
            pop_n = 2'd0;
        end else if (h0.exc_v) begin
            nxt_valid = 1'b1;
            nxt_pc    = h0.pc;
            nxt_exv   = 1'b1;
            nxt_exc   = h0.code;
            pop_n     = 2'd1;
            set_halt  = 1'b1;
        end else if (h0.data[1:0] != 2'b11) begin
            nxt_valid = 1'b1;
            nxt_pc    = h0.pc;
            nxt_instr = {16'b0, h0.data};
            nxt_half  = 1'b1;
            pop_n     = 2'd1;
        end else if (count >= CW'(2) && q[head_nx].exc_v) begin
            nxt_valid = 1'b1;
            nxt_pc    = h0.pc;
            nxt_exv   = 1'b1;
            nxt_exc   = q[head_nx].code;
            pop_n     = 2'd2;
            set_halt  = 1'b1;
        end else if (count >= CW'(2)) begin
            nxt_valid = 1'b1;
            nxt_pc    = h0.pc;
            nxt_instr = {q[head_nx].data, h0.data};
            pop_n     = 2'd2;
        end
    end

    // Halfword storage; contents are don't-care while count excludes them.
    always_ff @(posedge i_clk) begin
        if (push_n != 2'd0) begin
            q[tail] <= e0;
        end
        if (push_n == 2'd2) begin
            q[tail_nx] <= e1;
        end
    end

    // Queue pointers, occupancy and the post-fault halt flag.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            head   <= '0;
            tail   <= '0;
            count  <= '0;
            halted <= 1'b0;
        end else begin
            tail <= tail + PW'(push_n);
            if (!i_stall) begin
                head  <= head + PW'(pop_n);
                count <= count + CW'(push_n) - CW'(pop_n);
                if (set_halt) begin
                    halted <= 1'b1;
                end
            end else begin
                count <= count + CW'(push_n);
            end
        end
    end

    // Output register toward decode; holds while decode stalls.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            o_valid        <= 1'b0;
            o_pc           <= '0;
            o_instr        <= '0;
            o_half         <= 1'b0;
            o_except_valid <= 1'b0;
            o_except_code  <= '0;
        end else if (!i_stall) begin
            o_valid        <= nxt_valid;
            o_pc           <= nxt_pc;
            o_instr        <= nxt_instr;
            o_half         <= nxt_half;
            o_except_valid <= nxt_exv;
            o_except_code  <= nxt_exc;
        end
    end

endmodule
